memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter that shares the single byte-wide RAM between instruction fetch (opcode buffer) and the data load/store path. Each client issues one-byte read (or, for the data port, write) transactions with a pulse/busy handshake. The arbiter queues at most one transaction per client, grants the RAM round-robin, sequences the RAM request/busy protocol and returns read bytes to the owning client. It sits between the opcode buffer / load-store unit and the RAM model.

## Interface
- ADDRESS_WIDTH, 32, width of all byte addresses

- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state
- ifetch_request  in  1  one-cycle pulse: start a byte read at ifetch_address
- ifetch_address  in  ADDRESS_WIDTH  fetch byte address, sampled with ifetch_request
- ifetch_busy  out  1  fetch transaction pending or in flight
- ifetch_data  out  8  last byte read for fetch port; valid when ifetch_busy==0
- data_request  in  1  one-cycle pulse: start a byte transaction at data_address
- data_address  in  ADDRESS_WIDTH  data byte address, sampled with data_request
- data_write  in  1  1 = write data_wdata, 0 = read; sampled with data_request
- data_wdata  in  8  write byte, sampled with data_request
- data_busy  out  1  data transaction pending or in flight
- data_rdata  out  8  last byte read for data port; unchanged by writes
- ram_request  out  1  one-cycle RAM command strobe
- ram_address  out  ADDRESS_WIDTH  RAM byte address, held stable through ISSUE and WAIT
- ram_write  out  1  RAM write enable, qualifies ram_request
- ram_wdata  out  8  RAM write byte
- ram_data  in  8  RAM read byte
- ram_busy  in  1  RAM busy; read data valid in first WAIT cycle where ram_busy==0

## Operation
- Per client: pending flag plus latched address (and write/wdata for data port).
- Accept: at an edge where X_request==1 and X_busy==0, latch inputs, set pending; X_busy=1 from next cycle. Request while X_busy==1 is ignored; latched fields not overwritten.
- X_busy = pending OR in flight for that client; cleared by completion.
- FSM states IDLE, ISSUE, WAIT.
  - IDLE: if any pending flag set at the edge, select owner, load ram_address/ram_write/ram_wdata from owner latch, go ISSUE. Flags set at the same edge are not considered until the next edge.
  - ISSUE: ram_request=1 for exactly this cycle; next edge go WAIT unconditionally (ram_busy ignored in ISSUE).
  - WAIT: at each edge, if ram_busy==0: complete (read: capture ram_data into owner's data register; write: data register unchanged), clear owner pending, go IDLE. Else stay.
- Arbitration: round-robin with last_grant register. Only one pending -> grant it. Both pending -> grant the one not equal to last_grant. last_grant updated on grant. Reset value last_grant=ifetch, so first tie goes to data port.
- Outputs ram_request, ram_address, ram_write, ram_wdata, X_busy, X_data registered.
- Reset (reset==0 at edge) overrides all other activity including an in-flight RAM access: state IDLE, pending flags 0, last_grant=ifetch. All outputs 0: ifetch_busy, data_busy, ifetch_data, data_rdata, ram_request, ram_address, ram_write, ram_wdata.

## Timing
- Uncontended, RAM with ram_busy never high: request at edge E0 -> ISSUE after E1 (ram_request high E1..E2) -> WAIT after E2 -> completion at E3; X_busy high E0..E3, low and data valid after E3. Minimum latency 3 cycles.
- Each ram_busy-high WAIT cycle adds one cycle.
- New request at the edge where X_busy first reads 0 (E3+1) is accepted.
- Contended: second client's transaction issues at the edge after the first completes (IDLE one cycle), i.e. 3-cycle minimum spacing per RAM access.
- Starvation-free: a pending client waits at most one other transaction.

## Test plan
- Reset: hold reset=0 with both requests pulsed -> all outputs 0, no ram_request after release until a new request.
- Single fetch read addr 0x100, ram_data=0xA5, ram_busy=0 -> ram_request one cycle with ram_address=0x100, ram_write=0; ifetch_busy low 3 cycles after request, ifetch_data=0xA5.
- Simultaneous fetch read 0x10 and data write 0x20 (wdata 0x3C) after reset -> data write issued first (ram_write=1, ram_wdata=0x3C), then fetch read 0x10; data_rdata unchanged.
- RAM stalls: ram_busy high 4 cycles after ISSUE -> completion delayed 4 cycles, ram_address stable throughout, data captured only when ram_busy==0.
- Continuous back-to-back requests from both ports for 8 transactions -> grants strictly alternate; second request pulsed while busy is ignored (address not changed).
- reset=0 during WAIT of a data read -> FSM IDLE, data_busy=0, data_rdata=0; subsequent request completes normally.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bundle of the two client ports and the RAM port of the memory arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface memory_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32
);
    // Client handshake: X_request is a one-cycle pulse taken only while X_busy==0;
    // X_busy rises the cycle after acceptance and falls when the byte transaction
    // completes, at which point the X data output holds the read byte.
    // RAM handshake: ram_request strobes one cycle with address/write/wdata held
    // until completion; the access finishes at the first later edge with ram_busy==0.
    logic                     ifetch_request;
    logic [ADDRESS_WIDTH-1:0] ifetch_address;
    logic                     ifetch_busy;
    logic [7:0]               ifetch_data;

    logic                     data_request;
    logic [ADDRESS_WIDTH-1:0] data_address;
    logic                     data_write;
    logic [7:0]               data_wdata;
    logic                     data_busy;
    logic [7:0]               data_rdata;

    logic                     ram_request;
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic                     ram_write;
    logic [7:0]               ram_wdata;
    logic [7:0]               ram_data;
    logic                     ram_busy;

    modport slave (
        input  ifetch_request, ifetch_address,
        output ifetch_busy, ifetch_data,
        input  data_request, data_address, data_write, data_wdata,
        output data_busy, data_rdata,
        output ram_request, ram_address, ram_write, ram_wdata,
        input  ram_data, ram_busy
    );

    modport master (
        output ifetch_request, ifetch_address,
        input  ifetch_busy, ifetch_data,
        output data_request, data_address, data_write, data_wdata,
        input  data_busy, data_rdata,
        input  ram_request, ram_address, ram_write, ram_wdata,
        output ram_data, ram_busy
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM between instruction fetch and
// the load/store path; one queued transaction per client.
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    memory_arbiter_if.slave   bus,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic GRANT_IFETCH = 1'b0;
    localparam logic GRANT_DATA   = 1'b1;

    state_e                   state_q, state_d;

    logic                     if_pend_q, if_pend_d;
    logic [ADDRESS_WIDTH-1:0] if_addr_q, if_addr_d;
    logic [7:0]               if_data_q, if_data_d;

    logic                     dt_pend_q, dt_pend_d;
    logic [ADDRESS_WIDTH-1:0] dt_addr_q, dt_addr_d;
    logic                     dt_write_q, dt_write_d;
    logic [7:0]               dt_wdata_q, dt_wdata_d;
    logic [7:0]               dt_data_q, dt_data_d;

    logic                     last_grant_q, last_grant_d;
    logic                     owner_q, owner_d;
    logic                     grant;

    logic                     ram_request_q, ram_request_d;
    logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
    logic                     ram_write_q, ram_write_d;
    logic [7:0]               ram_wdata_q, ram_wdata_d;

    always_comb begin
        state_d       = state_q;
        if_pend_d     = if_pend_q;
        if_addr_d     = if_addr_q;
        if_data_d     = if_data_q;
        dt_pend_d     = dt_pend_q;
        dt_addr_d     = dt_addr_q;
        dt_write_d    = dt_write_q;
        dt_wdata_d    = dt_wdata_q;
        dt_data_d     = dt_data_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        grant         = GRANT_IFETCH;
        ram_request_d = 1'b0;
        ram_address_d = ram_address_q;
        ram_write_d   = ram_write_q;
        ram_wdata_d   = ram_wdata_q;

        // Requests seen while a client is already busy are dropped.
        if (bus.ifetch_request && !if_pend_q) begin
            if_pend_d = 1'b1;
            if_addr_d = bus.ifetch_address;
        end
        if (bus.data_request && !dt_pend_q) begin
            dt_pend_d  = 1'b1;
            dt_addr_d  = bus.data_address;
            dt_write_d = bus.data_write;
            dt_wdata_d = bus.data_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                // Only flags already registered take part, so a request landing
                // on this edge waits for the next arbitration round.
                if (if_pend_q || dt_pend_q) begin
                    if (if_pend_q && dt_pend_q) begin
                        grant = ~last_grant_q;
                    end else begin
                        grant = dt_pend_q ? GRANT_DATA : GRANT_IFETCH;
                    end
                    owner_d       = grant;
                    last_grant_d  = grant;
                    ram_request_d = 1'b1;
                    state_d       = ST_ISSUE;
                    if (grant == GRANT_DATA) begin
                        ram_address_d = dt_addr_q;
                        ram_write_d   = dt_write_q;
                        ram_wdata_d   = dt_wdata_q;
                    end else begin
                        ram_address_d = if_addr_q;
                        ram_write_d   = 1'b0;
                        ram_wdata_d   = 8'h00;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.ram_busy) begin
                    state_d = ST_IDLE;
                    if (owner_q == GRANT_DATA) begin
                        dt_pend_d = 1'b0;
                        if (!ram_write_q) begin
                            dt_data_d = bus.ram_data;
                        end
                    end else begin
                        if_pend_d = 1'b0;
                        if_data_d = bus.ram_data;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            if_pend_q     <= 1'b0;
            if_addr_q     <= '0;
            if_data_q     <= 8'h00;
            dt_pend_q     <= 1'b0;
            dt_addr_q     <= '0;
            dt_write_q    <= 1'b0;
            dt_wdata_q    <= 8'h00;
            dt_data_q     <= 8'h00;
            last_grant_q  <= GRANT_IFETCH;
            owner_q       <= GRANT_IFETCH;
            ram_request_q <= 1'b0;
            ram_address_q <= '0;
            ram_write_q   <= 1'b0;
            ram_wdata_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            if_pend_q     <= if_pend_d;
            if_addr_q     <= if_addr_d;
            if_data_q     <= if_data_d;
            dt_pend_q     <= dt_pend_d;
            dt_addr_q     <= dt_addr_d;
            dt_write_q    <= dt_write_d;
            dt_wdata_q    <= dt_wdata_d;
            dt_data_q     <= dt_data_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            ram_request_q <= ram_request_d;
            ram_address_q <= ram_address_d;
            ram_write_q   <= ram_write_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    // A client stays busy from acceptance through completion of its access.
    assign bus.ifetch_busy = if_pend_q;
    assign bus.ifetch_data = if_data_q;
    assign bus.data_busy   = dt_pend_q;
    assign bus.data_rdata  = dt_data_q;
    assign bus.ram_request = ram_request_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_write   = ram_write_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a RAM model with programmable stall, a command
// scoreboard checked on every ram_request, and one task per scenario.
module tb_memory_arbiter;

    localparam int AW = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_o;

    memory_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

    memory_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected RAM commands, packed {write, address, wdata}.
    logic [40:0]   exp_q[$];
    int            issue_cyc_q[$];
    logic [AW-1:0] cur_addr = '0;
    logic          prev_req = 1'b0;
    logic [7:0]    dt_model = 8'h00;

    int         stall_cfg = 0;
    int         stall_cnt = 0;
    logic [7:0] wr_mem[0:1023];
    bit         wr_valid[0:1023];

    function automatic logic [7:0] pattern(input logic [AW-1:0] a);
        return 8'hA5 ^ a[7:0] ^ {6'b0, a[9:8]} ^ 8'h01;
    endfunction

    // RAM model: writes land at the ISSUE edge, then ram_busy holds for stall_cfg cycles.
    always @(posedge clk) begin
        if (bus.ram_request) begin
            if (bus.ram_write) begin
                wr_mem[bus.ram_address[9:0]]   <= bus.ram_wdata;
                wr_valid[bus.ram_address[9:0]] <= 1'b1;
            end
            stall_cnt <= stall_cfg;
        end else if (stall_cnt != 0) begin
            stall_cnt <= stall_cnt - 1;
        end
    end

    assign bus.ram_busy = (stall_cnt != 0);
    assign bus.ram_data = bus.ram_busy ? 8'hEE :
                          (wr_valid[bus.ram_address[9:0]] ? wr_mem[bus.ram_address[9:0]]
                                                          : pattern(bus.ram_address));

    // Command monitor.
    always @(negedge clk) begin
        logic [40:0] e;
        cyc = cyc + 1;
        if (bus.ram_request === 1'b1) begin
            n_checks++;
            if (prev_req) begin
                n_errors++;
                $display("FAIL ram_request_width: got high two cycles, required one");
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_cmd: got addr %h write %b, required no command",
                         bus.ram_address, bus.ram_write);
            end else begin
                e = exp_q.pop_front();
                cur_addr = e[39:8];
                issue_cyc_q.push_back(cyc);
                if (bus.ram_address !== e[39:8] || bus.ram_write !== e[40] ||
                    (e[40] && bus.ram_wdata !== e[7:0])) begin
                    n_errors++;
                    $display("FAIL cmd: got w=%b a=%h d=%h, required w=%b a=%h d=%h",
                             bus.ram_write, bus.ram_address, bus.ram_wdata, e[40], e[39:8], e[7:0]);
                end
            end
        end
        if (state_o === 2'd2) begin
            n_checks++;
            if (bus.ram_address !== cur_addr) begin
                n_errors++;
                $display("FAIL ram_addr_stable: got %h required %h", bus.ram_address, cur_addr);
            end
        end
        prev_req = bus.ram_request;
    end

    task automatic pulse_ifetch(input logic [AW-1:0] a);
        bus.ifetch_request = 1'b1;
        bus.ifetch_address = a;
        @(negedge clk);
        bus.ifetch_request = 1'b0;
    endtask

    task automatic pulse_data(input logic [AW-1:0] a, input logic wr, input logic [7:0] wd);
        bus.data_request = 1'b1;
        bus.data_address = a;
        bus.data_write   = wr;
        bus.data_wdata   = wd;
        @(negedge clk);
        bus.data_request = 1'b0;
    endtask

    task automatic pulse_both(input logic [AW-1:0] ia, input logic [AW-1:0] da,
                              input logic wr, input logic [7:0] wd);
        bus.ifetch_request = 1'b1;
        bus.ifetch_address = ia;
        bus.data_request   = 1'b1;
        bus.data_address   = da;
        bus.data_write     = wr;
        bus.data_wdata     = wd;
        @(negedge clk);
        bus.ifetch_request = 1'b0;
        bus.data_request   = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
        dt_model = 8'h00;
    endtask

    task automatic wait_idle(input int limit);
        int g = 0;
        while ((bus.ifetch_busy || bus.data_busy) && g < limit) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (g >= limit) begin
            n_errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles, required idle", g);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        pulse_both(32'h100, 32'h104, 1'b1, 8'h99);
        @(negedge clk);
        n_checks += 8;
        if (bus.ifetch_busy !== 1'b0) begin n_errors++; $display("FAIL rst_ifetch_busy: got %b required 0", bus.ifetch_busy); end
        if (bus.data_busy !== 1'b0) begin n_errors++; $display("FAIL rst_data_busy: got %b required 0", bus.data_busy); end
        if (bus.ifetch_data !== 8'h00) begin n_errors++; $display("FAIL rst_ifetch_data: got %h required 00", bus.ifetch_data); end
        if (bus.data_rdata !== 8'h00) begin n_errors++; $display("FAIL rst_data_rdata: got %h required 00", bus.data_rdata); end
        if (bus.ram_request !== 1'b0) begin n_errors++; $display("FAIL rst_ram_request: got %b required 0", bus.ram_request); end
        if (bus.ram_address !== '0) begin n_errors++; $display("FAIL rst_ram_address: got %h required 0", bus.ram_address); end
        if (bus.ram_write !== 1'b0) begin n_errors++; $display("FAIL rst_ram_write: got %b required 0", bus.ram_write); end
        if (bus.ram_wdata !== 8'h00) begin n_errors++; $display("FAIL rst_ram_wdata: got %h required 00", bus.ram_wdata); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_checks += 2;
        if (bus.ifetch_busy !== 1'b0 || bus.data_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL post_rst_busy: got %b%b required 00", bus.ifetch_busy, bus.data_busy);
        end
        if (issue_cyc_q.size() != 0) begin
            n_errors++;
            $display("FAIL post_rst_issue: got %0d commands required 0", issue_cyc_q.size());
        end
    endtask

    task automatic test_single_fetch();
        int lat = 0;
        stall_cfg = 0;
        exp_q.push_back({1'b0, 32'h100, 8'h00});
        pulse_ifetch(32'h100);
        while (bus.ifetch_busy && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks += 2;
        if (lat != 3) begin n_errors++; $display("FAIL fetch_latency: got %0d required 3", lat); end
        if (bus.ifetch_data !== 8'hA5) begin n_errors++; $display("FAIL fetch_data: got %h required a5", bus.ifetch_data); end
    endtask

    task automatic test_simultaneous();
        apply_reset(2);
        issue_cyc_q.delete();
        exp_q.push_back({1'b1, 32'h20, 8'h3C});
        exp_q.push_back({1'b0, 32'h10, 8'h00});
        pulse_both(32'h10, 32'h20, 1'b1, 8'h3C);
        wait_idle(40);
        n_checks += 4;
        if (bus.ifetch_data !== pattern(32'h10)) begin
            n_errors++; $display("FAIL sim_fetch_data: got %h required %h", bus.ifetch_data, pattern(32'h10));
        end
        if (bus.data_rdata !== dt_model) begin
            n_errors++; $display("FAIL sim_data_rdata: got %h required %h", bus.data_rdata, dt_model);
        end
        if (wr_mem[10'h20] !== 8'h3C) begin
            n_errors++; $display("FAIL sim_ram_written: got %h required 3c", wr_mem[10'h20]);
        end
        if (issue_cyc_q.size() != 2 || (issue_cyc_q[1] - issue_cyc_q[0]) != 3) begin
            n_errors++; $display("FAIL sim_spacing: got %0d commands, required 2 spaced 3 cycles", issue_cyc_q.size());
        end
    endtask

    task automatic test_stall();
        int lat = 0;
        stall_cfg = 4;
        exp_q.push_back({1'b0, 32'h200, 8'h00});
        pulse_data(32'h200, 1'b0, 8'h00);
        while (bus.data_busy && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        dt_model = pattern(32'h200);
        n_checks += 2;
        if (lat != 7) begin n_errors++; $display("FAIL stall_latency: got %0d required 7", lat); end
        if (bus.data_rdata !== dt_model) begin
            n_errors++; $display("FAIL stall_data: got %h required %h", bus.data_rdata, dt_model);
        end
        stall_cfg = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] if_exp_q[$];
        logic [7:0] dt_exp_q[$];
        logic [7:0] e;
        logic if_prev, dt_prev;
        int fi = 0;
        int di = 0;
        int guard = 0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, AW'(32'h300 + k), 8'h00});
            exp_q.push_back({(k % 2 == 0), AW'(32'h380 + k), 8'(8'h40 + k)});
            if_exp_q.push_back(pattern(AW'(32'h300 + k)));
            if (k % 2 == 1) dt_model = pattern(AW'(32'h380 + k));
            dt_exp_q.push_back(dt_model);
        end
        while ((fi < 4 || di < 4 || bus.ifetch_busy || bus.data_busy) && guard < 400) begin
            if_prev = bus.ifetch_busy;
            dt_prev = bus.data_busy;
            if (!bus.ifetch_busy && fi < 4) begin
                bus.ifetch_request = 1'b1;
                bus.ifetch_address = AW'(32'h300 + fi);
                fi++;
            end else if (bus.ifetch_busy && $urandom_range(0, 1) == 1) begin
                bus.ifetch_request = 1'b1;
                bus.ifetch_address = 32'h3F0;
            end else begin
                bus.ifetch_request = 1'b0;
            end
            if (!bus.data_busy && di < 4) begin
                bus.data_request = 1'b1;
                bus.data_address = AW'(32'h380 + di);
                bus.data_write   = (di % 2 == 0);
                bus.data_wdata   = 8'(8'h40 + di);
                di++;
            end else if (bus.data_busy && $urandom_range(0, 1) == 1) begin
                bus.data_request = 1'b1;
                bus.data_address = 32'h3F8;
                bus.data_write   = 1'b1;
                bus.data_wdata   = 8'hFF;
            end else begin
                bus.data_request = 1'b0;
            end
            @(negedge clk);
            guard++;
            if (if_prev && !bus.ifetch_busy) begin
                n_checks++;
                e = (if_exp_q.size() > 0) ? if_exp_q.pop_front() : 8'hxx;
                if (bus.ifetch_data !== e) begin
                    n_errors++; $display("FAIL b2b_fetch_data: got %h required %h", bus.ifetch_data, e);
                end
            end
            if (dt_prev && !bus.data_busy) begin
                n_checks++;
                e = (dt_exp_q.size() > 0) ? dt_exp_q.pop_front() : 8'hxx;
                if (bus.data_rdata !== e) begin
                    n_errors++; $display("FAIL b2b_data_rdata: got %h required %h", bus.data_rdata, e);
                end
            end
        end
        bus.ifetch_request = 1'b0;
        bus.data_request   = 1'b0;
        n_checks += 2;
        if (guard >= 400) begin n_errors++; $display("FAIL b2b_timeout: got %0d cycles required under 400", guard); end
        if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL b2b_cmds_left: got %0d outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_during_wait();
        int g = 0;
        int lat = 0;
        stall_cfg = 10;
        exp_q.push_back({1'b0, 32'h210, 8'h00});
        pulse_data(32'h210, 1'b0, 8'h00);
        while (state_o !== 2'd2 && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        n_checks++;
        if (g >= 20) begin n_errors++; $display("FAIL rw_reach_wait: got state %0d required 2", state_o); end
        apply_reset(1);
        n_checks += 4;
        if (state_o !== 2'd0) begin n_errors++; $display("FAIL rw_state: got %0d required 0", state_o); end
        if (bus.data_busy !== 1'b0) begin n_errors++; $display("FAIL rw_data_busy: got %b required 0", bus.data_busy); end
        if (bus.data_rdata !== 8'h00) begin n_errors++; $display("FAIL rw_data_rdata: got %h required 00", bus.data_rdata); end
        if (bus.ram_request !== 1'b0) begin n_errors++; $display("FAIL rw_ram_request: got %b required 0", bus.ram_request); end
        stall_cfg = 0;
        exp_q.push_back({1'b0, 32'h211, 8'h00});
        pulse_data(32'h211, 1'b0, 8'h00);
        while (bus.data_busy && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        dt_model = pattern(32'h211);
        n_checks += 2;
        if (lat != 3) begin n_errors++; $display("FAIL rw_after_latency: got %0d required 3", lat); end
        if (bus.data_rdata !== dt_model) begin
            n_errors++; $display("FAIL rw_after_data: got %h required %h", bus.data_rdata, dt_model);
        end
    endtask

    initial begin
        reset              = 1'b0;
        bus.ifetch_request = 1'b0;
        bus.ifetch_address = '0;
        bus.data_request   = 1'b0;
        bus.data_address   = '0;
        bus.data_write     = 1'b0;
        bus.data_wdata     = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_stall();
        test_back_to_back();
        test_reset_during_wait();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
